// File: rtl/uart_imem_loader_pkg.sv
// Shared encodings and framing constants for the UART instruction-memory loader.
package uart_imem_loader_pkg;

    localparam int DATA_BITS  = 8;   // UART data bits per frame, LSB first
    localparam int STOP_BITS  = 1;   // UART stop bits per frame
    localparam int CNT_W      = 16;  // width of the word-count header
    localparam int WORD_BYTES = 4;   // bytes per instruction word

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [2:0] {
        L_IDLE   = 3'd0,
        L_CNT_LO = 3'd1,
        L_CNT_HI = 3'd2,
        L_DATA   = 3'd3,
        L_WRITE  = 3'd4,
        L_DONE   = 3'd5
    } ld_state_e;

    // The core is held in reset for every state of an active load.
    function automatic logic hold_for(input ld_state_e s);
        logic h;
        case (s)
            L_CNT_LO, L_CNT_HI, L_DATA, L_WRITE: h = 1'b1;
            default:                             h = 1'b0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/uart_imem_loader_rx.sv
// UART receiver: 2-flop synchronizer, start/data/stop sampling, byte and frame-error pulses.
module uart_rx
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    logic      rx_meta_q, rx_s_q;
    rx_state_e state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic       valid_q, valid_d, ferr_q, ferr_d;

    // Bring the asynchronous rx pin into the clk domain; idle level is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receiver next-state: mid-start check, then one sample per bit period.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    state_d = RX_START;
                    baud_d  = BAUD_ZERO;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d = BAUD_ZERO;
                    bit_d  = 3'd0;
                    if (!rx_s_q) begin
                        state_d = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;   // glitch, not a real start bit
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            RX_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = BAUD_ZERO;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            RX_STOP: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = BAUD_ZERO;
                    state_d = RX_IDLE;
                    if (rx_s_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Receiver state and registered byte/error outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            baud_q  <= BAUD_ZERO;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data    = data_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// UART boot loader: reads a word count and little-endian words, writes them to imem.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              load_en,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              frame_err
);

    logic [7:0] rx_byte_s;
    logic       byte_valid_s;

    ld_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, idx_q, idx_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] word_q, word_d;
    logic [CNT_W-1:0] cnt_hi_s;
    logic        in_range_s, we_d;
    logic        we_q, hold_q, done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0] wdata_q;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_data    (rx_byte_s),
        .byte_valid (byte_valid_s),
        .frame_err  (frame_err)
    );

    assign cnt_hi_s   = {rx_byte_s, cnt_q[7:0]};
    // Indices past the memory depth are consumed but never written (no wrap).
    assign in_range_s = ({1'b0, idx_q} < ({{CNT_W{1'b0}}, 1'b1} << ADDR_W));
    assign we_d       = (state_q == L_WRITE) && in_range_s;

    // Loader next-state: header, byte assembly, one-cycle write, abort on load_en low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        if ((state_q != L_IDLE) && !load_en) begin
            state_d = L_IDLE;
        end else begin
            case (state_q)
                L_IDLE: begin
                    if (load_en) state_d = L_CNT_LO;
                    else         state_d = L_IDLE;
                end
                L_CNT_LO: begin
                    if (byte_valid_s) begin
                        cnt_d   = {cnt_q[15:8], rx_byte_s};
                        state_d = L_CNT_HI;
                    end else begin
                        state_d = L_CNT_LO;
                    end
                end
                L_CNT_HI: begin
                    if (byte_valid_s) begin
                        cnt_d  = cnt_hi_s;
                        idx_d  = {CNT_W{1'b0}};
                        bidx_d = 2'd0;
                        if (cnt_hi_s == {CNT_W{1'b0}}) state_d = L_DONE;
                        else                           state_d = L_DATA;
                    end else begin
                        state_d = L_CNT_HI;
                    end
                end
                L_DATA: begin
                    if (byte_valid_s) begin
                        word_d = {rx_byte_s, word_q[31:8]};
                        if (bidx_q == 2'(WORD_BYTES - 1)) begin
                            bidx_d  = 2'd0;
                            state_d = L_WRITE;
                        end else begin
                            bidx_d  = bidx_q + 2'd1;
                        end
                    end else begin
                        state_d = L_DATA;
                    end
                end
                L_WRITE: begin
                    idx_d = idx_q + 16'd1;
                    if ((idx_q + 16'd1) == cnt_q) state_d = L_DONE;
                    else                          state_d = L_DATA;
                end
                L_DONE:  state_d = L_DONE;
                default: state_d = L_IDLE;
            endcase
        end
    end

    // Loader state, assembly registers and registered write-port/status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= L_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            idx_q   <= {CNT_W{1'b0}};
            bidx_q  <= 2'd0;
            word_q  <= 32'd0;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= 32'd0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            we_q    <= we_d;
            if (we_d) begin
                addr_q  <= idx_q[ADDR_W-1:0];
                wdata_q <= word_q;
            end else begin
                addr_q  <= addr_q;
                wdata_q <= wdata_q;
            end
            hold_q  <= hold_for(state_d);
            done_q  <= (state_d == L_DONE);
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench: random load streams against a queue-based model of expected writes.
module tb_uart_imem_loader;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, rx, load_en;
    logic          imem_we, cpu_hold, done, frame_err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    int total = 0;
    int bad   = 0;

    logic [31:0]   exp_words [0:15];
    logic [AW-1:0] obs_addr [$];
    logic [31:0]   obs_data [$];
    int fe_cnt = 0, fe_long = 0, hold_cnt = 0;
    logic fe_prev = 1'b0;

    always #5 clk = ~clk;

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .load_en    (load_en),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .frame_err  (frame_err)
    );

    // Record write-port traffic and frame-error pulses away from the active edge.
    always @(negedge clk) begin
        if (imem_we) begin
            obs_addr.push_back(imem_addr);
            obs_data.push_back(imem_wdata);
        end
        if (frame_err) fe_cnt++;
        if (frame_err && fe_prev) fe_long++;
        fe_prev = frame_err;
        if (cpu_hold) hold_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Count header then each word LSB byte first; bad_pos inserts a corrupted frame first.
    task automatic send_stream(input int n, input int bad_pos);
        logic [15:0] nn;
        logic [7:0]  b;
        nn = 16'(n);
        send_byte(nn[7:0], 1'b1);
        send_byte(nn[15:8], 1'b1);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = exp_words[w][8*k +: 8];
                if (w * 4 + k == bad_pos) send_byte(b ^ 8'h5A, 1'b0);
                send_byte(b, 1'b1);
            end
        end
        repeat (6 * CPB) @(negedge clk);
    endtask

    // Model: word i goes to address i only while i fits the memory depth.
    task automatic check_writes(input string tag, input int n, input int base);
        int nexp;
        int nobs;
        nexp = (n < DEPTH) ? n : DEPTH;
        nobs = obs_addr.size() - base;
        check_val({tag, "_nwr"}, 32'(nobs), 32'(nexp));
        for (int i = 0; i < nexp; i++) begin
            if (i < nobs) begin
                check_val({tag, "_addr"}, 32'(obs_addr[base + i]), 32'(i));
                check_val({tag, "_data"}, obs_data[base + i], exp_words[i]);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_we"},    32'(imem_we),    32'd0);
        check_val({tag, "_addr"},  32'(imem_addr),  32'd0);
        check_val({tag, "_wdata"}, imem_wdata,      32'd0);
        check_val({tag, "_hold"},  32'(cpu_hold),   32'd0);
        check_val({tag, "_done"},  32'(done),       32'd0);
        check_val({tag, "_ferr"},  32'(frame_err),  32'd0);
    endtask

    task automatic rand_words();
        for (int i = 0; i < 16; i++) exp_words[i] = $urandom;
    endtask

    initial begin
        int base;
        int n;
        int hold_base;
        int fe_base;
        int fl_base;
        rx      = 1'b1;
        load_en = 1'b0;
        reset   = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b1;
        @(negedge clk);

        // Directed two-word stream from the reference program.
        exp_words[0] = 32'h00100513;
        exp_words[1] = 32'h00B505B3;
        base = obs_addr.size();
        load_en = 1'b1;
        @(negedge clk);
        check_val("arm_hold", 32'(cpu_hold), 32'd1);
        send_stream(2, -1);
        check_writes("dir", 2, base);
        check_val("dir_done", 32'(done), 32'd1);
        check_val("dir_hold", 32'(cpu_hold), 32'd0);
        load_en = 1'b0;
        @(negedge clk);
        check_val("dir_done_drop", 32'(done), 32'd0);

        // Zero-length load: done immediately, hold only during the header.
        base = obs_addr.size();
        hold_base = hold_cnt;
        load_en = 1'b1;
        @(negedge clk);
        send_stream(0, -1);
        check_writes("zero", 0, base);
        check_val("zero_done", 32'(done), 32'd1);
        check_val("zero_hold", 32'(cpu_hold), 32'd0);
        check_val("zero_hold_len", 32'((hold_cnt - hold_base > 0) && (hold_cnt - hold_base < 2 * 12 * CPB + 4)), 32'd1);
        load_en = 1'b0;
        @(negedge clk);

        // Corrupted stop bit mid-word, then the same byte resent correctly.
        rand_words();
        base = obs_addr.size();
        fe_base = fe_cnt;
        fl_base = fe_long;
        load_en = 1'b1;
        @(negedge clk);
        send_stream(1, 1);
        check_val("ferr_pulses", 32'(fe_cnt - fe_base), 32'd1);
        check_val("ferr_width", 32'(fe_long - fl_base), 32'd0);
        check_writes("ferr", 1, base);
        load_en = 1'b0;
        @(negedge clk);

        // Abort after two data bytes, then a full reload.
        rand_words();
        base = obs_addr.size();
        load_en = 1'b1;
        @(negedge clk);
        send_byte(8'd1, 1'b1);
        send_byte(8'd0, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        check_val("abort_hold_pre", 32'(cpu_hold), 32'd1);
        load_en = 1'b0;
        @(negedge clk);
        check_val("abort_hold", 32'(cpu_hold), 32'd0);
        repeat (20) @(negedge clk);
        check_val("abort_nwr", 32'(obs_addr.size() - base), 32'd0);
        load_en = 1'b1;
        @(negedge clk);
        send_stream(1, -1);
        check_writes("rearm", 1, base);
        load_en = 1'b0;
        @(negedge clk);

        // N=5 past the depth, then random lengths.
        for (int r = 0; r < 4; r++) begin
            n = (r == 0) ? 5 : int'($urandom_range(1, 7));
            rand_words();
            base = obs_addr.size();
            load_en = 1'b1;
            @(negedge clk);
            send_stream(n, -1);
            check_writes("rnd", n, base);
            check_val("rnd_done", 32'(done), 32'd1);
            load_en = 1'b0;
            repeat (2) @(negedge clk);
        end

        // One-cycle low glitch while waiting for the header must not be a byte.
        rand_words();
        fe_base = fe_cnt;
        load_en = 1'b1;
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check_val("glitch_ferr", 32'(fe_cnt - fe_base), 32'd0);
        base = obs_addr.size();
        send_stream(1, -1);
        check_writes("glitch", 1, base);
        load_en = 1'b0;
        @(negedge clk);

        // Reset in the middle of a data byte clears everything.
        load_en = 1'b1;
        @(negedge clk);
        send_byte(8'd1, 1'b1);
        send_byte(8'd0, 1'b1);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check_val("mid_hold_pre", 32'(cpu_hold), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        rand_words();
        base = obs_addr.size();
        send_stream(1, -1);
        check_writes("postrst", 1, base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- UART boot loader: the writer side of the instruction memory that the controller decodes from.
- Receives a framed byte stream on the UART rx pin and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through a simple write port.
- Holds the processor in reset while a load is in progress.

Parameters:
- CLKS_PER_BIT, 10416: clk cycles per UART bit (100 MHz / 9600 baud); must be >= 4.
- ADDR_W, 8: instruction memory word-address width; depth = 2**ADDR_W words.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- rx  input  1  UART serial input; idle high; asynchronous to clk.
- load_en  input  1  level; 1 = loader armed/active, 0 = abort/idle.
- imem_we  output  1  one-cycle write strobe to instruction memory.
- imem_addr  output  ADDR_W  word address of the current write.
- imem_wdata  output  32  instruction word being written.
- cpu_hold  output  1  1 = keep processor core in reset.
- done  output  1  1 = load completed; held until load_en falls.
- frame_err  output  1  one-cycle pulse: bad stop bit, byte discarded.

Behaviour:
- Reset (reset==0 at clk edge): imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, frame_err=0; both rx synchronizer flops = 1; RX FSM = RX_IDLE; loader FSM = L_IDLE; all counters = 0. Reset mid-frame or mid-load discards everything.
- rx passes through a 2-flop synchronizer. The RX FSM sees rx_s, which lags rx by 2 cycles.
- RX FSM states and transitions:
  - RX_IDLE: on rx_s==0, go to RX_START.
  - RX_START: wait CLKS_PER_BIT/2 cycles (integer divide). If rx_s==0, go to RX_DATA; else return to RX_IDLE (glitch rejected, no error).
  - RX_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - RX_STOP: sample once after CLKS_PER_BIT cycles. If 1, byte_valid pulses for 1 cycle. If 0, frame_err pulses for 1 cycle and the byte is dropped. Return to RX_IDLE in both cases.
- Stream format: word count N (16-bit, little-endian, 2 bytes), then 4*N bytes. Each word arrives little-endian (byte0 = instr[7:0]).
- Loader FSM states and transitions:
  - L_IDLE: go to L_CNT_LO when load_en==1.
  - L_CNT_LO: next byte -> N[7:0].
  - L_CNT_HI: next byte -> N[15:8]. If N==0, go to L_DONE; else go to L_DATA with word index=0 and byte index=0.
  - L_DATA: shift bytes into the word register. On the 4th byte, go to L_WRITE.
  - L_WRITE: exactly one cycle. imem_we=1 with imem_addr=index[ADDR_W-1:0] and imem_wdata = assembled word. Then increment the index. If index+1==N, go to L_DONE; else return to L_DATA.
  - L_DONE: done=1. Go to L_IDLE when load_en==0.
- Words with index >= 2**ADDR_W are received and counted, but imem_we stays 0 (no address wrap).
- cpu_hold = 1 in L_CNT_LO, L_CNT_HI, L_DATA and L_WRITE; 0 in L_IDLE and L_DONE. It is a registered output.
- load_en==0 in any state other than L_IDLE: next state is L_IDLE. The partial word is discarded, cpu_hold and done drop, and the RX FSM keeps running.
- Bytes arriving while in L_IDLE or L_DONE are ignored.
- A frame error leaves the loader state unchanged; the erroneous byte is simply not counted.
- A byte can never arrive during L_WRITE: the minimum byte spacing is 10*CLKS_PER_BIT cycles.
- Latency: imem_we asserts 2 cycles after the byte_valid pulse of the 4th byte of a word.

Decomposition:
- Shared package holds: loader and RX state encodings; the UART framing constants (8 data bits, 1 stop bit); the word-count field width (16).
- One sub-module is natural: uart_rx (synchronizer, RX FSM, baud counter). It provides rx_data[7:0], byte_valid and frame_err, with the same clk/reset and CLKS_PER_BIT.
- The loader FSM, word assembly and write port live in the top.

Test Plan:
- CLKS_PER_BIT=4, load_en=1, send 02 00 13 05 10 00 B3 05 B5 00 -> imem_we pulses twice: addr 0 with 0x00100513, addr 1 with 0x00B505B3. done=1 and cpu_hold=0 after the 2nd write.
- Send count bytes 00 00 -> L_DONE immediately, done=1, no imem_we, cpu_hold high for only the count phase.
- Drive a byte with stop bit=0 in the middle of a word -> frame_err pulses exactly 1 cycle. Resend the byte correctly -> the word is written intact at the expected address.
- Drop load_en to 0 after 2 data bytes -> cpu_hold=0 next cycle, no write. Re-arm and send a full stream -> the word is written at addr 0.
- ADDR_W=2, N=5 -> writes at addr 0..3 only, 5th word consumed with no imem_we, done=1.
- A 1-cycle low glitch on rx while idle -> no byte_valid, no frame_err. Assert reset mid-byte -> all outputs 0 next cycle.
